dmem_arbiter: RTL and testbench

Sequencing controller and two-port arbiter in front of the byte-addressed, 64-bit-wide `Data_Mem`. It accepts load/store requests from two requesters: port 0 is the CPU load/store unit and port 1 is the debug/loader port. It grants them round-robin and drives the memory's address and read/write controls. It converts byte, half, word and doubleword accesses into full 8-byte memory transfers: read-modify-write for sub-word stores, and extract plus sign or zero extension for loads.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_lane.sv | 22 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and default memory depth for the data-memory arbiter
package dmem_pkg;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;
   localparam int DMEM_SIZE = 9192;
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-lane extract/extend for loads and low-byte merge for sub-word stores
//   size, uns     : access size encoding and zero-extend flag
//   mem_dw, wdata : doubleword read from memory, right-justified store data
//   load_val      : extended load result
//   store_dw      : mem_dw with its low 2^size bytes replaced from wdata
module dmem_lane import dmem_pkg::*; (
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [63:0] mem_dw,
   input  logic [63:0] wdata,
   output logic [63:0] load_val,
   output logic [63:0] store_dw
);
   always_comb begin
      load_val = size == SZ_B ? {{56{~uns & mem_dw[7]}}, mem_dw[7:0]} :
                 size == SZ_H ? {{48{~uns & mem_dw[15]}}, mem_dw[15:0]} :
                 size == SZ_W ? {{32{~uns & mem_dw[31]}}, mem_dw[31:0]} : mem_dw;
      store_dw = size == SZ_B ? {mem_dw[63:8], wdata[7:0]} :
                 size == SZ_H ? {mem_dw[63:16], wdata[15:0]} :
                 size == SZ_W ? {mem_dw[63:32], wdata[31:0]} : wdata;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin load/store sequencer in front of a 64-bit byte-addressed memory
//   p0_*/p1_*            : requester ports (req/we/addr/size/unsigned/wdata in, ack/err/rdata out)
//   mem_addr/rw/wdata    : registered memory controls, stable through ACCESS/WRITE
//   mem_rdata            : combinational memory read data
module dmem_arbiter import dmem_pkg::*; #(
   parameter int SIZE = DMEM_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [63:0] p0_addr,
   input  logic [1:0]  p0_size,
   input  logic        p0_unsigned,
   input  logic [63:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [63:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [63:0] p1_addr,
   input  logic [1:0]  p1_size,
   input  logic        p1_unsigned,
   input  logic [63:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [63:0] p1_rdata,
   output logic [63:0] mem_addr,
   output logic        mem_rw,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);
   state_t state;
   logic last, gnt, we, uns, ack, err, sel, s_we, s_uns;
   logic [1:0] size, s_size;
   logic [63:0] rdata, s_addr, s_wdata, load_val, store_dw;
   always_comb begin
      sel = p0_req & p1_req ? ~last : p1_req;
      s_we = sel ? p1_we : p0_we;
      s_addr = sel ? p1_addr : p0_addr;
      s_size = sel ? p1_size : p0_size;
      s_uns = sel ? p1_unsigned : p0_unsigned;
      s_wdata = sel ? p1_wdata : p0_wdata;
   end
   assign p0_ack = ack & ~gnt;
   assign p1_ack = ack & gnt;
   assign p0_err = err & ~gnt;
   assign p1_err = err & gnt;
   assign p0_rdata = gnt ? '0 : rdata;
   assign p1_rdata = gnt ? rdata : '0;
   // mem_wdata doubles as the latched store data until WRITE overwrites it with the merge
   dmem_lane u_lane (
      .size(size),
      .uns(uns),
      .mem_dw(mem_rdata),
      .wdata(mem_wdata),
      .load_val(load_val),
      .store_dw(store_dw)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last <= 1'b1;
         gnt <= 1'b0;
         we <= 1'b0;
         uns <= 1'b0;
         size <= SZ_B;
         ack <= 1'b0;
         err <= 1'b0;
         rdata <= '0;
         mem_addr <= '0;
         mem_rw <= 1'b0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (p0_req | p1_req) begin
               gnt <= sel;
               last <= sel;
               we <= s_we;
               uns <= s_uns;
               size <= s_size;
               if (s_addr > 64'(SIZE - 8)) begin
                  state <= RESP;
                  ack <= 1'b1;
                  err <= 1'b1;
               end else begin
                  state <= ACCESS;
                  mem_addr <= s_addr;
                  mem_rw <= s_we && s_size == SZ_D;
                  mem_wdata <= s_wdata;
               end
            end
            ACCESS: if (we && size != SZ_D) begin
               state <= WRITE;
               mem_rw <= 1'b1;
               mem_wdata <= store_dw;
            end else begin
               state <= RESP;
               mem_rw <= 1'b0;
               ack <= 1'b1;
               rdata <= we ? '0 : load_val;
            end
            WRITE: begin
               state <= RESP;
               mem_rw <= 1'b0;
               ack <= 1'b1;
            end
            RESP: begin
               state <= IDLE;
               ack <= 1'b0;
               err <= 1'b0;
               rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector bench for dmem_arbiter with a little-endian byte memory model
module tb_dmem_arbiter;
   localparam int SIZE = 9192;
   logic clk = 0, rst = 1;
   logic p0_req = 0, p0_we = 0, p0_unsigned = 0, p1_req = 0, p1_we = 0, p1_unsigned = 0;
   logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic [1:0] p0_size = 0, p1_size = 0;
   logic p0_ack, p0_err, p1_ack, p1_err, mem_rw;
   logic [63:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [7:0] mem [0:SIZE-1];
   int n_cmp = 0, n_fail = 0;
   typedef struct {
      logic port; logic we; logic [63:0] addr; logic [1:0] size; logic uns; logic [63:0] wdata;
      int cyc; logic err; logic [63:0] rdata; int nrw; logic [63:0] wd;
   } vec_t;
   vec_t vecs[19];
   dmem_arbiter #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
      .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
      .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   always_comb begin
      mem_rdata = '0;
      for (int i = 0; i < 8; i++)
         if (mem_addr + 64'(i) < 64'(SIZE)) mem_rdata[8*i +: 8] = mem[int'(mem_addr) + i];
   end
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < SIZE; i++) mem[i] <= 8'h00;
      end else if (mem_rw) begin
         for (int i = 0; i < 8; i++)
            if (mem_addr + 64'(i) < 64'(SIZE)) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
      end
   end
   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic port, input logic req, input logic we, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata);
      if (port) begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wdata;
      end else begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wdata;
      end
   endtask
   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
   endtask
   task automatic apply(input int idx, input vec_t v);
      int got, nrw;
      logic other, a;
      got = -1; nrw = 0; other = 0;
      @(posedge clk); #1;
      drive(v.port, 1, v.we, v.addr, v.size, v.uns, v.wdata);
      for (int k = 1; k <= 6 && got < 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) drive(v.port, 0, ~v.we, 64'h0BAD_F00D_0BAD_F00D, ~v.size, ~v.uns, 64'h5A5A_A5A5_5A5A_A5A5);
         if (mem_rw) begin
            nrw++;
            chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wd);
         end
         a = v.port ? p1_ack : p0_ack;
         if (v.port ? p0_ack : p1_ack) other = 1;
         if (a) begin
            got = k;
            chk($sformatf("v%0d err", idx), 64'(v.port ? p1_err : p0_err), 64'(v.err));
            chk($sformatf("v%0d rdata", idx), v.port ? p1_rdata : p0_rdata, v.rdata);
         end
      end
      chk($sformatf("v%0d ack_cycle", idx), 64'(got), 64'(v.cyc));
      chk($sformatf("v%0d write_cycles", idx), 64'(nrw), 64'(v.nrw));
      chk($sformatf("v%0d other_ack", idx), 64'(other), 64'(0));
   endtask
   initial begin
      int gp[4], gc[4], n;
      logic both, any_ack;
      vecs[0]  = '{0, 1, 64'h10, 2'd3, 0, 64'h0123456789ABCDEF, 2, 0, 64'h0, 1, 64'h0123456789ABCDEF};
      vecs[1]  = '{0, 0, 64'h10, 2'd3, 0, 64'h0, 2, 0, 64'h0123456789ABCDEF, 0, 64'h0};
      vecs[2]  = '{1, 1, 64'h12, 2'd0, 0, 64'h77665544332211AA, 3, 0, 64'h0, 1, 64'h00000123456789AA};
      vecs[3]  = '{0, 0, 64'h10, 2'd3, 0, 64'h0, 2, 0, 64'h0123456789AACDEF, 0, 64'h0};
      vecs[4]  = '{0, 0, 64'h12, 2'd0, 0, 64'h0, 2, 0, 64'hFFFFFFFFFFFFFFAA, 0, 64'h0};
      vecs[5]  = '{1, 0, 64'h12, 2'd0, 1, 64'h0, 2, 0, 64'h00000000000000AA, 0, 64'h0};
      vecs[6]  = '{0, 0, 64'h11, 2'd1, 0, 64'h0, 2, 0, 64'hFFFFFFFFFFFFAACD, 0, 64'h0};
      vecs[7]  = '{0, 0, 64'h10, 2'd2, 0, 64'h0, 2, 0, 64'hFFFFFFFF89AACDEF, 0, 64'h0};
      vecs[8]  = '{1, 1, 64'h13, 2'd1, 0, 64'h000000001234BEEF, 3, 0, 64'h0, 1, 64'h000000012345BEEF};
      vecs[9]  = '{0, 0, 64'h12, 2'd2, 1, 64'h0, 2, 0, 64'h0000000045BEEFAA, 0, 64'h0};
      vecs[10] = '{1, 0, 64'h13, 2'd1, 0, 64'h0, 2, 0, 64'hFFFFFFFFFFFFBEEF, 0, 64'h0};
      vecs[11] = '{0, 0, 64'd9185, 2'd3, 0, 64'h0, 1, 1, 64'h0, 0, 64'h0};
      vecs[12] = '{1, 1, 64'd9184, 2'd3, 0, 64'h1122334455667788, 2, 0, 64'h0, 1, 64'h1122334455667788};
      vecs[13] = '{1, 0, 64'd9184, 2'd3, 0, 64'h0, 2, 0, 64'h1122334455667788, 0, 64'h0};
      vecs[14] = '{0, 1, 64'd9190, 2'd0, 0, 64'h55, 1, 1, 64'h0, 0, 64'h0};
      vecs[15] = '{0, 0, 64'hFFFFFFFFFFFFFFF8, 2'd3, 0, 64'h0, 1, 1, 64'h0, 0, 64'h0};
      vecs[16] = '{1, 1, 64'h20, 2'd2, 0, 64'hFFFFFFFFDEADBEEF, 3, 0, 64'h0, 1, 64'h00000000DEADBEEF};
      vecs[17] = '{0, 0, 64'h20, 2'd3, 0, 64'h0, 2, 0, 64'h00000000DEADBEEF, 0, 64'h0};
      vecs[18] = '{0, 0, 64'h20, 2'd2, 0, 64'h0, 2, 0, 64'hFFFFFFFFDEADBEEF, 0, 64'h0};
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst mem_rw", 64'(mem_rw), 64'(0));
      chk("rst mem_addr", mem_addr, 64'h0);
      chk("rst mem_wdata", mem_wdata, 64'h0);
      chk("rst acks", {62'h0, p1_ack, p0_ack}, 64'h0);
      chk("rst errs", {62'h0, p1_err, p0_err}, 64'h0);
      chk("rst p0_rdata", p0_rdata, 64'h0);
      chk("rst p1_rdata", p1_rdata, 64'h0);
      rst = 0;
      // both ports request continuously from the first cycle after reset
      drive(0, 1, 0, 64'h10, 2'd3, 0, 64'h0);
      drive(1, 1, 0, 64'h10, 2'd3, 0, 64'h0);
      n = 0; both = 0;
      for (int i = 0; i < 4; i++) begin gp[i] = -1; gc[i] = -1; end
      for (int k = 1; k <= 20 && n < 4; k++) begin
         @(posedge clk); #1;
         if (p0_ack && p1_ack) both = 1;
         if (p0_ack || p1_ack) begin gp[n] = int'(p1_ack); gc[n] = k; n++; end
      end
      p0_req = 0; p1_req = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("arb grant%0d", i), 64'(gp[i]), 64'(i % 2));
         chk($sformatf("arb cycle%0d", i), 64'(gc[i]), 64'(2 + 3 * i));
      end
      chk("arb both_ack", 64'(both), 64'(0));
      do_reset();
      for (int i = 0; i < 19; i++) apply(i, vecs[i]);
      // reset lands in the ACCESS cycle of a p1 sub-word store
      @(posedge clk); #1;
      drive(1, 1, 1, 64'h30, 2'd0, 0, 64'h66);
      @(posedge clk); #1;
      p1_req = 0;
      chk("rstmid access_addr", mem_addr, 64'h30);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rstmid mem_rw", 64'(mem_rw), 64'(0));
      chk("rstmid mem_addr", mem_addr, 64'h0);
      any_ack = p0_ack | p1_ack;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (p0_ack || p1_ack || mem_rw) any_ack = 1;
      end
      chk("rstmid no_ack", 64'(any_ack), 64'(0));
      drive(0, 1, 0, 64'h30, 2'd3, 0, 64'h0);
      drive(1, 1, 0, 64'h30, 2'd3, 0, 64'h0);
      gp[0] = -1; gc[0] = -1;
      for (int k = 1; k <= 6 && gc[0] < 0; k++) begin
         @(posedge clk); #1;
         if (p0_ack || p1_ack) begin gp[0] = int'(p1_ack); gc[0] = k; end
      end
      p0_req = 0; p1_req = 0;
      chk("rstmid next_grant", 64'(gp[0]), 64'(0));
      chk("rstmid next_cycle", 64'(gc[0]), 64'(2));
      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
